add_sub_64bit_reg: RTL and testbench
====================================

Name: add_sub_64bit_reg

Overview:
- 64-bit two's-complement adder/subtractor with registered outputs, used as the integer add/sub datapath slice of the ALU.
- `mode` selects the operation: 0 = a+b, 1 = a−b.
- Outputs are sum/difference, raw carry-out and a signed-overflow flag, all captured one cycle after inputs are presented with `in_valid`.

Parameters:
- WIDTH, 64, operand/result width. Must be a multiple of 16; verified only at 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  1  0 = add, 1 = subtract
- out_valid  output  1  s/cout/ovf hold a new result
- s  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of the MSB
- ovf  output  1  signed overflow

Behaviour:
- Reset: when rst_n=0, asynchronously clear out_valid, s, cout and ovf to 0. They stay 0 until the first accepted operation after rst_n rises.
- Datapath (combinational core):
  - b_eff = b XOR {WIDTH{mode}}.
  - cin = mode.
  - {c, sum} = a + b_eff + cin, computed at full WIDTH+1 precision.
- Subtract convention: cout=1 means no borrow, i.e. a >= b unsigned. cout=0 means a borrow occurred.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). This is valid for both modes.
- Latency: exactly 1 cycle.
  - On a rising clk edge with in_valid=1: s<=sum, cout<=c, ovf<=ovf_comb, out_valid<=1.
  - On a rising edge with in_valid=0: out_valid<=0; s/cout/ovf hold their previous values.
- Throughput: one operation per cycle. No backpressure and no stall input.
- Wrap-around: the result is always modulo 2^WIDTH. No saturation; ovf and cout are flags only.
- mode is sampled together with a/b on the same edge. Changing mode between cycles has no side effects.
- Reset mid-operation: a result in flight is discarded and out_valid=0. The first operation after reset deasserts produces a valid result on the following edge.
- No X propagation from unused inputs: when in_valid=0 the output registers do not load.

Decomposition:
- Shared package alu_pkg:
  - constant XLEN=64.
  - localparam encodings ALU_OP_ADD=1'b0 and ALU_OP_SUB=1'b1 for mode.
- Sub-module cla_16: 16-bit carry-lookahead adder.
  - Inputs: a[15:0], b[15:0], cin.
  - Outputs: sum[15:0], group generate G, group propagate P, cout.
  - Internally it uses four 4-bit lookahead groups.
- Top instantiates WIDTH/16 cla_16 blocks and a second-level lookahead unit across the group G/P signals to form the inter-block carries. The top also contains the mode XOR, the ovf logic and the output registers.

Test Plan:
- Add small: mode=0, a=2, b=3 -> next cycle s=5, cout=0, ovf=0, out_valid=1.
- Add signed overflow: mode=0, a=0x7FFFFFFFFFFFFFFF, b=1 -> s=0x8000000000000000, cout=0, ovf=1. Also a=0x7FFFFFFFFFFFFFFE, b=1 -> s=0x7FFFFFFFFFFFFFFF, ovf=0.
- Subtract, positive and negative results:
  - mode=1, a=7, b=5 -> s=2, cout=1, ovf=0.
  - mode=1, a=5, b=7 -> s=0xFFFFFFFFFFFFFFFE, cout=0, ovf=0.
- Subtract negatives: mode=1, a=0xFFFFFFFFFFFFFFFD (−3), b=0xFFFFFFFFFFFFFFFB (−5) -> s=2, cout=1, ovf=0.
- Subtract overflow at min: mode=1, a=0x8000000000000000, b=1 -> s=0x7FFFFFFFFFFFFFFF, cout=1, ovf=1.
- Control:
  - Back-to-back ops on consecutive cycles each produce a result exactly 1 cycle later.
  - in_valid=0 -> out_valid=0 and s holds its value.
  - Assert rst_n=0 asynchronously mid-stream -> all outputs 0 immediately, without waiting for a clk edge.
  - Carry chain: mode=0, a=0xFFFFFFFFFFFFFFFF, b=1 -> s=0, cout=1, ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU constants and the carry-lookahead helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int   XLEN       = 64;
    localparam int   CLA_BLK_W  = 16;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Carry into position n (0..4) of a 4-wide generate/propagate group,
    // built as a flat sum of products so no carry ripples between positions.
    function automatic logic cla4_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin,
        input int         n
    );
        logic v_acc;
        logic v_term;
        v_acc = cin;
        for (int k = 0; k < 4; k++) begin
            if (k < n) v_acc = v_acc & p[k];
        end
        for (int j = 0; j < 4; j++) begin
            if (j < n) begin
                v_term = g[j];
                for (int k = 0; k < 4; k++) begin
                    if ((k > j) && (k < n)) v_term = v_term & p[k];
                end
                v_acc = v_acc | v_term;
            end
        end
        return v_acc;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/add_sub_64bit_reg_cla_16.sv
`default_nettype none
// ============================================================================
// Module      : cla_16
// Description : 16-bit carry-lookahead adder made of four 4-bit groups,
//               exporting block generate/propagate for a higher lookahead level.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_16
    import alu_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_g,
    output logic        o_p,
    output logic        o_cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_grp_g;
    logic [3:0]  w_grp_p;
    logic [3:0]  w_grp_cin;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_grp
            assign w_grp_g[k]   = cla4_carry(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0, 4);
            assign w_grp_p[k]   = &w_p[4*k +: 4];
            assign w_grp_cin[k] = cla4_carry(w_grp_g, w_grp_p, i_cin, k);
            for (genvar n = 0; n < 4; n++) begin : g_bit
                assign w_c[4*k + n] = cla4_carry(w_g[4*k +: 4], w_p[4*k +: 4], w_grp_cin[k], n);
            end
        end
    endgenerate

    assign o_sum  = w_p ^ w_c;
    assign o_g    = cla4_carry(w_grp_g, w_grp_p, 1'b0, 4);
    assign o_p    = &w_grp_p;
    assign o_cout = cla4_carry(w_grp_g, w_grp_p, i_cin, 4);

endmodule : cla_16
`default_nettype wire

// File: rtl/add_sub_64bit_reg.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_64bit_reg
// Description : Two's-complement adder/subtractor with registered result,
//               carry-out and signed-overflow flag (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_64bit_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / CLA_BLK_W;

    logic             w_is_sub;
    logic             w_cin;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [NBLK-1:0]  w_blk_g;
    logic [NBLK-1:0]  w_blk_p;
    logic [NBLK-1:0]  w_blk_cout;
    logic [NBLK:0]    w_blk_c;
    logic             w_ovf;
    logic             w_unused_blk_cout;

    logic             r_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    // Subtraction is a + ~b + 1.
    assign w_is_sub = (mode == ALU_OP_SUB);
    assign w_b_eff  = b ^ {WIDTH{w_is_sub}};
    assign w_cin    = w_is_sub;

    generate
        for (genvar i = 0; i < NBLK; i++) begin : g_blk
            cla_16 u_cla (
                .i_a    (a[CLA_BLK_W*i +: CLA_BLK_W]),
                .i_b    (w_b_eff[CLA_BLK_W*i +: CLA_BLK_W]),
                .i_cin  (w_blk_c[i]),
                .o_sum  (w_sum[CLA_BLK_W*i +: CLA_BLK_W]),
                .o_g    (w_blk_g[i]),
                .o_p    (w_blk_p[i]),
                .o_cout (w_blk_cout[i])
            );
        end
    endgenerate

    // Second-level lookahead: every block carry-in is a flat sum of products
    // over block generate/propagate, so no carry ripples across blocks.
    always_comb begin : p_lookahead
        logic v_acc;
        logic v_term;
        w_blk_c = '0;
        v_acc   = 1'b0;
        v_term  = 1'b0;
        for (int i = 0; i <= NBLK; i++) begin
            v_acc = w_cin;
            for (int k = 0; k < NBLK; k++) begin
                if (k < i) v_acc = v_acc & w_blk_p[k];
            end
            for (int j = 0; j < NBLK; j++) begin
                if (j < i) begin
                    v_term = w_blk_g[j];
                    for (int k = 0; k < NBLK; k++) begin
                        if ((k > j) && (k < i)) v_term = v_term & w_blk_p[k];
                    end
                    v_acc = v_acc | v_term;
                end
            end
            w_blk_c[i] = v_acc;
        end
    end

    // Block carry-outs are superseded by the lookahead carry vector.
    assign w_unused_blk_cout = ^w_blk_cout;

    assign w_ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s    <= w_sum;
                r_cout <= w_blk_c[NBLK];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule : add_sub_64bit_reg
`default_nettype wire

// File: tb/tb_add_sub_64bit_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_sub_64bit_reg
// Description : Self-checking bench for add_sub_64bit_reg with an arithmetic
//               reference model and directed corner vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_64bit_reg;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        mode;
    logic        out_valid;
    logic [63:0] s;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    // Model of what the output registers should currently hold
    logic        m_valid;
    logic [63:0] m_s;
    logic        m_cout;
    logic        m_ovf;

    always #5 clk = ~clk;

    add_sub_64bit_reg #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: plain arithmetic, unsigned compare for borrow, sign rules for overflow
    function automatic logic [65:0] ref_op(input logic [63:0] x, input logic [63:0] y, input logic md);
        logic [64:0] full;
        logic [63:0] r;
        logic        c;
        logic        o;
        if (md == ALU_OP_ADD) begin
            full = {1'b0, x} + {1'b0, y};
            c    = full[64];
        end else begin
            full = {1'b0, x} - {1'b0, y};
            c    = (x >= y);
        end
        r = full[63:0];
        if (md == ALU_OP_ADD) o = (x[63] == y[63]) && (r[63] != x[63]);
        else                  o = (x[63] != y[63]) && (r[63] != x[63]);
        return {r, c, o};
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'h1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Present one cycle of stimulus and advance the model to the post-edge state
    task automatic drive_op(input logic [63:0] x, input logic [63:0] y, input logic md, input logic v);
        @(negedge clk);
        a        = x;
        b        = y;
        mode     = md;
        in_valid = v;
        @(posedge clk);
        #1;
        m_valid = v;
        if (v) {m_s, m_cout, m_ovf} = ref_op(x, y, md);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 64'h1234;
        b        = 64'h5678;
        mode     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, s, cout, ovf} !== 67'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b s=%h c=%b o=%b, want all zero", out_valid, s, cout, ovf);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        {m_valid, m_s, m_cout, m_ovf} = '0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, s, cout, ovf} !== 67'h0) begin
            errors++;
            $display("FAIL reset_idle: got v=%b s=%h c=%b o=%b, want all zero", out_valid, s, cout, ovf);
        end
    endtask

    task automatic test_directed();
        logic [63:0] t_a  [9] = '{64'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFE,
                                  64'h7, 64'h5, 64'hFFFF_FFFF_FFFF_FFFD,
                                  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        logic [63:0] t_b  [9] = '{64'h3, 64'h1, 64'h1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFB,
                                  64'h1, 64'h1, 64'h0};
        logic        t_m  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] t_s  [9] = '{64'h5, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                                  64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2,
                                  64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        logic        t_c  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        t_o  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive_op(t_a[i], t_b[i], t_m[i], 1'b1);
            checks++;
            if ({out_valid, s, cout, ovf} !== {1'b1, t_s[i], t_c[i], t_o[i]}) begin
                errors++;
                $display("FAIL directed_%0d: got v=%b s=%h c=%b o=%b, want v=1 s=%h c=%b o=%b",
                         i, out_valid, s, cout, ovf, t_s[i], t_c[i], t_o[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if ({out_valid, s, cout, ovf} !== {m_valid, m_s, m_cout, m_ovf}) begin
                errors++;
                $display("FAIL back_to_back_%0d: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                         i, out_valid, s, cout, ovf, m_valid, m_s, m_cout, m_ovf);
            end
        end
    endtask

    task automatic test_hold();
        drive_op(64'h1111_2222_3333_4444, 64'h0000_0000_0000_0001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if ({out_valid, s, cout, ovf} !== {1'b0, 64'h1111_2222_3333_4445, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b s=%h c=%b o=%b, want v=0 s=1111222233334445 c=0 o=0",
                         i, out_valid, s, cout, ovf);
            end
        end
        for (int i = 0; i < 60; i++) begin
            drive_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if ({out_valid, s, cout, ovf} !== {m_valid, m_s, m_cout, m_ovf}) begin
                errors++;
                $display("FAIL mixed_valid_%0d: got v=%b s=%h c=%b o=%b, want v=%b s=%h c=%b o=%b",
                         i, out_valid, s, cout, ovf, m_valid, m_s, m_cout, m_ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        a        = 64'h8000_0000_0000_0000;
        b        = 64'h1;
        mode     = 1'b1;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, s, cout, ovf} !== 67'h0) begin
            errors++;
            $display("FAIL async_reset_immediate: got v=%b s=%h c=%b o=%b, want all zero",
                     out_valid, s, cout, ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, s, cout, ovf} !== 67'h0) begin
            errors++;
            $display("FAIL async_reset_held: got v=%b s=%h c=%b o=%b, want all zero", out_valid, s, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        {m_valid, m_s, m_cout, m_ovf} = '0;
        drive_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1);
        checks++;
        if ({out_valid, s, cout, ovf} !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL after_reset_first_op: got v=%b s=%h c=%b o=%b, want v=1 s=7fffffffffffffff c=1 o=1",
                     out_valid, s, cout, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_add_sub_64bit_reg
`default_nettype wire
